serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the team's single-bit `full_adder` cell (ports a, b, ci, sum, co). The block consumes one operand bit pair per clock and registers the carry between cycles. It delivers a parallel WIDTH-bit result plus carry-out with a start/busy/done handshake. It is the sequential stage directly downstream of the `full_adder` cell, giving the datapath a low-area multi-bit adder.

---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a single
// full_adder cell, with a start/busy/done handshake and a registered parallel result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .ci  (r_carry),
    .sum (w_sum),
    .co  (w_co)
  );

  // Sum bits enter at the MSB so that bit 0 lands in position 0 after WIDTH shifts.
  assign w_sum_next = {w_sum, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= w_sum_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_result <= w_sum_next;
            r_cout   <= w_co;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected
// {cout,result}, a negedge monitor pops and compares on every done pulse.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int           errors = 0;
  int           checks = 0;
  int           done_count = 0;
  int           cyc = 0;
  int           txn = 0;
  logic [W:0]   sb[$];
  int           done_cyc[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: exclusivity of busy/done every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    logic [W:0] exp_v;
    if (rst_n) begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        done_count++;
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result=0x%0h cout=%0b, expected no done", result, cout);
        end else begin
          exp_v = sb.pop_front();
          txn++;
          $display("txn %0d: result=0x%02h cout=%0b expected=0x%03h", txn, result, cout, exp_v);
          check("sum", {23'd0, cout, result}, {23'd0, exp_v});
        end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit push);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    if (push) sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    int dc0;
    int n;
    logic [W-1:0] ra, rb;
    logic         rc;

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Basic add with cycle-exact busy/done timing
    start_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("t1_busy", {31'd0, busy}, {31'd0, (k <= 8)});
      check("t1_done", {31'd0, done}, {31'd0, (k == 9)});
    end

    // 2. Carry ripple
    start_op(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done("t2a");
    start_op(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done("t2b");

    // 3. Start during RUN is ignored; result holds until done
    #1;
    dc0 = done_count;
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    op_a  = 8'hAA;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
      check("t3_hold", {24'd0, result}, 32'h0000_00FF);
    end
    repeat (12) @(negedge clk);
    check("t3_one_done", done_count - dc0, 32'd1);

    // 4. Reset mid-operation
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_result", {24'd0, result}, 32'd0);
    check("t4_cout", {31'd0, cout}, 32'd0);
    dc0 = done_count;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_no_done", done_count - dc0, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    start_op(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done("t4");

    // 5. Back-to-back with start held through DONE
    @(negedge clk);
    op_a  = 8'h80;
    op_b  = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(9'h100);
    #1;
    op_a = 8'h0F;
    op_b = 8'hF0;
    cin  = 1'b1;
    wait_done("t5a");
    @(posedge clk);
    sb.push_back(9'h100);
    #1 start = 1'b0;
    wait_done("t5b");
    #1;
    if (done_cyc.size() >= 2)
      check("t5_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 32'd9);
    else
      check("t5_done_pulses", done_cyc.size(), 32'd2);

    // 6. Random operands
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc, 1'b1);
      wait_done("t6");
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
